// File: rtl/fpm_pkg.sv
// Constants shared by the floating-point mantissa datapaths (adder, multiplier).
package fpm_pkg;
  localparam int MANT_W = 24;
  localparam int SEG_W  = 12;
endpackage

// File: rtl/rca_seg.sv
// One ripple-carry segment: purely combinational SEG-bit add with carry in/out.
module rca_seg #(
  parameter int SEG = 12
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s   = sum[SEG-1:0];
  assign co  = sum[SEG];
endmodule

// File: rtl/pipe_rca_adder.sv
// Segmented add/subtract pipeline: one SEG-bit ripple segment per stage, with skewed
// operand/sum registers and a valid-ready handshake that stalls the whole pipe at once.
module pipe_rca_adder
  import fpm_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int SEG   = SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] a_pipe [NSEG];
  logic [WIDTH-1:0] b_pipe [NSEG];
  logic [WIDTH-1:0] s_pipe [NSEG];
  logic             c_pipe [NSEG];
  logic             v_pipe [NSEG];

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1, so the inverted operand and forced carry enter stage 0.
  assign a_pipe[0] = a;
  assign b_pipe[0] = sub ? ~b : b;
  assign c_pipe[0] = sub | cin;
  assign s_pipe[0] = '0;
  assign v_pipe[0] = in_valid;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic [WIDTH-1:0] s_d;

    rca_seg #(.SEG(SEG)) u_seg (
      .a  (a_pipe[k][k*SEG +: SEG]),
      .b  (b_pipe[k][k*SEG +: SEG]),
      .ci (c_pipe[k]),
      .s  (seg_s),
      .co (seg_co)
    );

    always_comb begin
      s_d = s_pipe[k];
      s_d[k*SEG +: SEG] = seg_s;
    end

    if (k < NSEG-1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (adv) begin
          v_q <= v_pipe[k];
          c_q <= seg_co;
          a_q <= a_pipe[k];
          b_q <= b_pipe[k];
          s_q <= s_d;
        end
      end

      assign v_pipe[k+1] = v_q;
      assign c_pipe[k+1] = c_q;
      assign a_pipe[k+1] = a_q;
      assign b_pipe[k+1] = b_q;
      assign s_pipe[k+1] = s_q;
    end else begin : g_last
      logic             v_q;
      logic             c_q;
      logic             ovf_q;
      logic             ovf_d;
      logic [WIDTH-1:0] s_q;

      // Operand MSBs arrive here through the skew registers alongside the top segment.
      assign ovf_d = (a_pipe[k][WIDTH-1] == b_pipe[k][WIDTH-1]) &&
                     (s_d[WIDTH-1] != a_pipe[k][WIDTH-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          ovf_q <= 1'b0;
          s_q   <= '0;
        end else if (adv) begin
          v_q   <= v_pipe[k];
          c_q   <= seg_co;
          ovf_q <= ovf_d;
          s_q   <= s_d;
        end
      end

      assign out_valid = v_q;
      assign s         = s_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
    end
  end
endmodule

// File: tb/tb_pipe_rca_adder.sv
// Bench for pipe_rca_adder: directed vectors and handshake scenarios on the 24/12 build,
// randomized streams on 24/12, 32/8 and 16/16 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipe_rca_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, cin, sub;

  logic [23:0] a0, b0, s0;
  logic        in_ready0, out_valid0, cout0, ovf0;
  logic [31:0] a1, b1, s1;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] a2, b2, s2;
  logic        in_ready2, out_valid2, cout2, ovf2;

  int tests = 0;
  int fails = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];

  pipe_rca_adder #(.WIDTH(24), .SEG(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin), .sub(sub), .out_valid(out_valid0),
    .out_ready(out_ready), .s(s0), .cout(cout0), .ovf(ovf0));

  pipe_rca_adder #(.WIDTH(32), .SEG(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready), .s(s1), .cout(cout1), .ovf(ovf1));

  pipe_rca_adder #(.WIDTH(16), .SEG(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin), .sub(sub), .out_valid(out_valid2),
    .out_ready(out_ready), .s(s2), .cout(cout2), .ovf(ovf2));

  // Reference: {ovf, cout, s zero-extended to 32} from plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    longint m, ua, ub, r, half, sa, sbv, t;
    logic [33:0] res;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    r    = sb ? ua + (~ub & m) + 1 : ua + ub + longint'(ci);
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    t    = sb ? sa - sbv : sa + sbv + longint'(ci);
    res[31:0] = 32'(r & m);
    res[32]   = r[w];
    res[33]   = (t >= half) || (t < -half);
    return res;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a0 = 24'h123456; b0 = 24'h654321; cin = 1'b1; sub = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    tests++;
    if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
    tests++;
    if ({ovf0, cout0, s0} !== 26'h0) begin
      fails++; $display("FAIL reset_outputs got ovf=%b cout=%b s=%h want all 0", ovf0, cout0, s0);
    end
    a0 = 24'h000123; b0 = 24'h000456; cin = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b0) begin fails++; $display("FAIL first_latency got out_valid=%b want 0", out_valid0); end
    @(negedge clk);
    tests++;
    if ({out_valid0, cout0, s0} !== {1'b1, 1'b0, 24'h000579}) begin
      fails++; $display("FAIL first_accept got v=%b cout=%b s=%h want v=1 cout=0 s=000579", out_valid0, cout0, s0);
    end
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b0) begin fails++; $display("FAIL first_dup got out_valid=%b want 0", out_valid0); end
  endtask

  task automatic test_vectors();
    logic [23:0] va[6] = '{24'h000FFF, 24'hFFFFFF, 24'h7FFFFF, 24'h000005, 24'h800000, 24'hFFFFFF};
    logic [23:0] vb[6] = '{24'h000001, 24'h000000, 24'h000001, 24'h000007, 24'h000001, 24'hFFFFFF};
    logic        vc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [23:0] es[6] = '{24'h001000, 24'h000000, 24'h800000, 24'hFFFFFE, 24'h7FFFFF, 24'hFFFFFF};
    logic        ec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        eo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0 = va[i]; b0 = vb[i]; cin = vc[i]; sub = vs[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid0 !== 1'b0) begin fails++; $display("FAIL vec%0d_latency got out_valid=%b want 0", i, out_valid0); end
      @(negedge clk);
      tests++;
      if ({out_valid0, ovf0, cout0, s0} !== {1'b1, eo[i], ec[i], es[i]}) begin
        fails++;
        $display("FAIL vec%0d got v=%b s=%h cout=%b ovf=%b want v=1 s=%h cout=%b ovf=%b",
                 i, out_valid0, s0, cout0, ovf0, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] ta[6], tb_b[6], held;
    logic        tc[6], tsub[6];
    logic [33:0] e[6];
    int nin = 0, nout = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      ta[i] = 24'($urandom); tb_b[i] = 24'($urandom);
      tc[i] = 1'($urandom_range(0, 1)); tsub[i] = 1'($urandom_range(0, 1));
      e[i] = model(24, 32'(ta[i]), 32'(tb_b[i]), tc[i], tsub[i]);
    end
    for (int cyc = 0; cyc < 30 && nout < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (nin < 6);
      if (nin < 6) begin a0 = ta[nin]; b0 = tb_b[nin]; cin = tc[nin]; sub = tsub[nin]; end
      #1;
      if (!out_ready) begin
        tests++;
        if (in_ready0 !== 1'b0) begin fails++; $display("FAIL stall_in_ready cyc%0d got %b want 0", cyc, in_ready0); end
        if (cyc == 4) held = s0;
        else begin
          tests++;
          if (s0 !== held) begin fails++; $display("FAIL stall_hold cyc%0d got s=%h want %h", cyc, s0, held); end
        end
      end
      if (in_valid && in_ready0) nin++;
      if (out_valid0 && out_ready) begin
        tests++;
        if ({ovf0, cout0, 8'h00, s0} !== e[nout]) begin
          fails++; $display("FAIL stall_result%0d got %h want %h", nout, {ovf0, cout0, 8'h00, s0}, e[nout]);
        end
        nout++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (nin != 6 || nout != 6) begin fails++; $display("FAIL stall_count got in=%0d out=%0d want 6/6", nin, nout); end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (out_valid0 !== 1'b0) begin fails++; $display("FAIL stall_dup got out_valid=%b want 0", out_valid0); end
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a0 = 24'h000111; b0 = 24'h000222; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    a0 = 24'h000333; b0 = 24'h000444;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid0 !== 1'b1) begin fails++; $display("FAIL flush_setup got out_valid=%b want 1", out_valid0); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid0, in_ready0} !== 2'b01) begin
      fails++; $display("FAIL flush_async got v=%b rdy=%b want v=0 rdy=1", out_valid0, in_ready0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (out_valid0 !== 1'b0) begin fails++; $display("FAIL flush_stale got out_valid=%b s=%h want 0", out_valid0, s0); end
    end
  endtask

  task automatic test_random();
    logic [33:0] exp;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int cyc = 0; cyc < 10010; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a0 = ($urandom_range(0, 7) == 0) ? '1 : 24'($urandom);
        b0 = ($urandom_range(0, 7) == 0) ? '1 : 24'($urandom);
        a1 = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
        b1 = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
        a2 = ($urandom_range(0, 7) == 0) ? '1 : 16'($urandom);
        b2 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (in_valid && in_ready0) q0.push_back(model(24, 32'(a0), 32'(b0), cin, sub));
      if (out_valid0 && out_ready) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL rand_w24 unexpected result s=%h", s0); end
        else begin
          exp = q0.pop_front();
          if ({ovf0, cout0, 8'h00, s0} !== exp) begin
            fails++; $display("FAIL rand_w24 cyc%0d got %h want %h", cyc, {ovf0, cout0, 8'h00, s0}, exp);
          end
        end
      end
      if (in_valid && in_ready1) q1.push_back(model(32, a1, b1, cin, sub));
      if (out_valid1 && out_ready) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL rand_w32 unexpected result s=%h", s1); end
        else begin
          exp = q1.pop_front();
          if ({ovf1, cout1, s1} !== exp) begin
            fails++; $display("FAIL rand_w32 cyc%0d got %h want %h", cyc, {ovf1, cout1, s1}, exp);
          end
        end
      end
      if (in_valid && in_ready2) q2.push_back(model(16, 32'(a2), 32'(b2), cin, sub));
      if (out_valid2 && out_ready) begin
        tests++;
        if (q2.size() == 0) begin fails++; $display("FAIL rand_w16 unexpected result s=%h", s2); end
        else begin
          exp = q2.pop_front();
          if ({ovf2, cout2, 16'h0000, s2} !== exp) begin
            fails++; $display("FAIL rand_w16 cyc%0d got %h want %h", cyc, {ovf2, cout2, 16'h0000, s2}, exp);
          end
        end
      end
    end
    tests++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      fails++; $display("FAIL rand_drain got pending %0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_vectors();
    test_stall();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_rca_adder.md
PIPE_RCA_ADDER -- requirements
Module: pipe_rca_adder

Interface
REQ-001 Parameter WIDTH, default 24: operand and sum width in bits.
REQ-002 Parameter SEG, default 12: ripple segment width; WIDTH SHALL be an integer multiple of SEG, with NSEG = WIDTH/SEG >= 1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  the input operand set is valid this cycle.
REQ-006 in_ready  out  1  the block accepts the input operand set this cycle.
REQ-007 a, b  in  WIDTH  operands.
REQ-008 cin  in  1  carry-in, used only when sub=0.
REQ-009 sub  in  1  0 = add, 1 = subtract.
REQ-010 out_valid  out  1  the result is valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 s  out  WIDTH  sum or difference.
REQ-013 cout  out  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-014 ovf  out  1  two's-complement signed overflow.

Function
REQ-015 Arithmetic: sub=0 gives {cout,s} = a + b + cin; sub=1 gives {cout,s} = a + ~b + 1, and cin is ignored.
REQ-016 Pipeline: NSEG register stages. Stage k adds segment k (bits k*SEG+SEG-1 : k*SEG) using the registered carry from stage k-1.
REQ-017 In each stage, the upper operand segments not yet consumed and the lower sum segments already produced SHALL be carried forward in skew registers.
REQ-018 Latency: a transfer accepted at edge T presents its result with out_valid=1 after edge T+NSEG-1 when there is no stall, i.e. NSEG cycles.
REQ-019 An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
REQ-020 Advance enable: adv = out_ready || !out_valid. in_ready SHALL equal adv combinationally. When adv=0, every stage register, valid bit included, holds its value.
REQ-021 Each stage carries a valid bit. Bubbles propagate but are not collapsed; throughput is 1 result per cycle while out_ready=1.
REQ-022 ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), where b_eff = sub ? ~b : b. It is computed in the final stage from the delayed MSBs.
REQ-023 s, cout and ovf are driven directly from the final-stage registers. They hold stable while out_valid=1 && out_ready=0.
REQ-024 in_valid=0 with adv=1 SHALL insert a bubble. Input data is don't-care and SHALL NOT change any result in flight.
REQ-025 Simultaneous input and output transfer in one cycle SHALL be lossless.
REQ-026 With NSEG=1 the block degenerates to one registered full-width adder with the same handshake.
REQ-027 Operands of all-ones width and carry ripple across every segment boundary SHALL produce the correct cout.

Reset
REQ-028 While rst_n=0, all stage valid bits clear, so out_valid=0 and in_ready=1; s, cout and ovf are 0.
REQ-029 Assertion of rst_n mid-operation SHALL discard all in-flight results; none of them appear after release.
REQ-030 The first input transfer is accepted on the first rising edge on which rst_n=1 and in_valid=1.

Structure
REQ-031 The shared package fpm_pkg SHALL hold the constants MANT_W=24 and SEG_W=12, used as the defaults here and by the multiplier datapath. No typedefs are required.
REQ-032 One combinational sub-module, rca_seg (SEG-bit ripple adder: a, b, ci -> s, co), SHALL be instantiated NSEG times via generate.
REQ-033 Skew registers and valid bits SHALL be generate arrays in pipe_rca_adder; there are no other sub-modules.

Verification (WIDTH=24, SEG=12, NSEG=2)
REQ-034 a=0x000FFF, b=0x000001, cin=0, sub=0, out_ready=1 -> after 2 cycles s=0x001000, cout=0, ovf=0 (carry crosses the segment boundary).
REQ-035 a=0xFFFFFF, b=0x000000, cin=1, sub=0 -> s=0x000000, cout=1. a=0x7FFFFF, b=0x000001, cin=0 -> s=0x800000, ovf=1.
REQ-036 a=0x000005, b=0x000007, sub=1, cin=1 -> s=0xFFFFFE, cout=0, ovf=0. a=0x800000, b=0x000001, sub=1 -> s=0x7FFFFF, ovf=1.
REQ-037 Stream 6 back-to-back inputs, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, s held stable, all 6 results in order, none lost or duplicated.
REQ-038 Drop rst_n for 1 cycle with 2 results in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-039 Random 10k vectors with random in_valid and out_ready, checked against a reference model for WIDTH=24/SEG=12, WIDTH=32/SEG=8 and WIDTH=16/SEG=16 -> zero mismatches.
